pipe_hazard_ctrl: RTL



---
 rtl/pipe_hazard_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: tracks in-flight writers from EX to WB and derives
// operand forwarding selects, the load-use stall and the branch flush.

module hazard_src #(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int FSW      = 2
) (
  input  logic                          id_valid,
  input  logic                          use_src,
  input  logic [REG_AW-1:0]             src,
  input  logic [DEPTH:1]                e_valid,
  input  logic [DEPTH:1]                e_rw,
  input  logic [DEPTH:1]                e_mr,
  input  logic [DEPTH:1][REG_AW-1:0]    e_wr,
  output logic [FSW-1:0]                fwd,
  output logic                          load_use
);
  // Walk oldest to youngest so the youngest matching producer is left standing.
  always_comb begin
    fwd      = '0;
    load_use = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (id_valid && use_src && e_valid[k] && e_rw[k] &&
          e_wr[k] == src && src != '0) begin
        fwd      = FSW'(k);
        load_use = (k <= LOAD_LAT) && e_mr[k];
      end
    end
  end
endmodule

module pipe_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int BR_STAGE = 2,
  parameter int FSW      = $clog2(DEPTH+1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_con_id_valid,
  input  logic [REG_AW-1:0] i_addr_id_rs,
  input  logic [REG_AW-1:0] i_addr_id_rt,
  input  logic              i_con_id_use_rs,
  input  logic              i_con_id_use_rt,
  input  logic [REG_AW-1:0] i_addr_id_wr,
  input  logic              i_con_id_regwrite,
  input  logic              i_con_id_memread,
  input  logic              i_con_br_taken,
  output logic              o_con_stall,
  output logic              o_con_flush,
  output logic [FSW-1:0]    o_con_fwd_rs,
  output logic [FSW-1:0]    o_con_fwd_rt,
  output logic [31:0]       o_data_stall_cnt
);
  logic [DEPTH:1]             e_valid, e_rw, e_mr;
  logic [DEPTH:1][REG_AW-1:0] e_wr;
  logic [1:0][REG_AW-1:0]     src;
  logic [1:0]                 use_src, load_use;
  logic [1:0][FSW-1:0]        fwd;
  logic                       stall, flush;
  logic [31:0]                stall_cnt;

  assign src     = {i_addr_id_rt, i_addr_id_rs};
  assign use_src = {i_con_id_use_rt, i_con_id_use_rs};

  generate
    for (genvar g = 0; g < 2; g++) begin : g_src
      hazard_src #(
        .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .FSW(FSW)
      ) u_src (
        .id_valid (i_con_id_valid),
        .use_src  (use_src[g]),
        .src      (src[g]),
        .e_valid  (e_valid),
        .e_rw     (e_rw),
        .e_mr     (e_mr),
        .e_wr     (e_wr),
        .fwd      (fwd[g]),
        .load_use (load_use[g])
      );
    end
  endgenerate

  // Flush wins over stall; both are held low while reset is asserted.
  assign flush = i_con_br_taken & i_rst_n;
  assign stall = (|load_use) & ~i_con_br_taken & i_rst_n;

  assign o_con_stall      = stall;
  assign o_con_flush      = flush;
  assign o_con_fwd_rs     = fwd[0];
  assign o_con_fwd_rt     = fwd[1];
  assign o_data_stall_cnt = stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      e_valid   <= '0;
      e_rw      <= '0;
      e_mr      <= '0;
      e_wr      <= '0;
      stall_cnt <= '0;
    end else begin
      e_valid[1] <= i_con_id_valid & ~stall & ~flush;
      e_rw[1]    <= i_con_id_regwrite;
      e_mr[1]    <= i_con_id_memread;
      e_wr[1]    <= i_addr_id_wr;
      // Wrong-path entries younger than the branch become bubbles on flush.
      for (int k = 2; k <= DEPTH; k++) begin
        e_valid[k] <= e_valid[k-1] & ~(flush && (k <= BR_STAGE));
        e_rw[k]    <= e_rw[k-1];
        e_mr[k]    <= e_mr[k-1];
        e_wr[k]    <= e_wr[k-1];
      end
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
endmodule
